// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the VGA frame buffer.
// Swap FSM states, bank index type and default geometry.
package vga_fb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 17;
    localparam int DEPTH_DEF      = 76800;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_SWAP
    } swap_state_e;

    typedef logic bank_idx_t;

endpackage

// File: rtl/vga_fb_bank.sv
// One byte-enable RAM bank with a registered read port.
// Contents are never reset; read is read-first on address collision.
module vga_fb_bank
    import vga_fb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_q
);

    localparam int BW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Byte-masked write and registered read of the old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BW; i++) begin
            if (we && wr_be[i]) begin
                mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        if (re) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vga_frame_buf.sv
// VGA frame buffer: byte-enable writes, 2-cycle reads, optional banks.
// Define VGA_FB_DOUBLE_BUF_EN for front/back banks with a swap FSM.
module vga_frame_buf
    import vga_fb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    active_bank,
    output logic                    addr_err
);

    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  s1_valid;
    logic                  s1_oor;
    logic [DATA_WIDTH-1:0] q_sel;

    assign wr_ok = wr_addr < LIMIT;
    assign rd_ok = rd_addr < LIMIT;

    // Read pipeline: stage 1 is the bank register, stage 2 the output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            s1_valid <= rd_en;
            s1_oor   <= rd_en && !rd_ok;
            rd_valid <= s1_valid;
            if (s1_valid) begin
                rd_data <= s1_oor ? '0 : q_sel;
            end
            addr_err <= (wr_en && !wr_ok) || (rd_en && !rd_ok);
        end
    end

`ifdef VGA_FB_DOUBLE_BUF_EN

    swap_state_e           state;
    bank_idx_t             wr_bank;
    bank_idx_t             s1_bank;
    logic [DATA_WIDTH-1:0] q0;
    logic [DATA_WIDTH-1:0] q1;

    // During the swap cycle writes still target the pre-swap back bank.
    assign wr_bank = (state == S_SWAP) ? active_bank : ~active_bank;
    assign q_sel   = s1_bank ? q1 : q0;

    vga_fb_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank0 (
        .clk     (clk),
        .we      (wr_en && wr_ok && (wr_bank == 1'b0)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .re      (rd_en && rd_ok),
        .rd_addr (rd_addr),
        .rd_q    (q0)
    );

    vga_fb_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank1 (
        .clk     (clk),
        .we      (wr_en && wr_ok && (wr_bank == 1'b1)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .re      (rd_en && rd_ok),
        .rd_addr (rd_addr),
        .rd_q    (q1)
    );

    // Remember which bank a read was issued against.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_bank <= 1'b0;
        end else if (rd_en) begin
            s1_bank <= active_bank;
        end
    end

    // Swap FSM: wait for the read pipeline to drain, then flip banks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            swap_ack    <= 1'b0;
            active_bank <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (swap_req) begin
                        state <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (!rd_en && !s1_valid && !rd_valid) begin
                        state       <= S_SWAP;
                        swap_ack    <= 1'b1;
                        active_bank <= ~active_bank;
                    end
                end
                S_SWAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`else

    vga_fb_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank0 (
        .clk     (clk),
        .we      (wr_en && wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .re      (rd_en && rd_ok),
        .rd_addr (rd_addr),
        .rd_q    (q_sel)
    );

    assign active_bank = 1'b0;

    // Single bank: a swap is acknowledged immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= swap_req;
        end
    end

`endif

endmodule

// File: tb/tb_vga_frame_buf.sv
// Self-checking bench for vga_frame_buf (either VGA_FB_DOUBLE_BUF_EN build).
// Directed cases followed by random traffic against a cycle-indexed model.
module tb_vga_frame_buf;

    localparam int DW    = 32;
    localparam int AW    = 17;
    localparam int DEPTH = 76800;
    localparam int NCYC  = 4096;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          swap_req;
    logic          swap_ack;
    logic          active_bank;
    logic          addr_err;

    vga_frame_buf #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .active_bank (active_bank),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected outputs indexed by cycle number.
    bit          exp_rv   [NCYC];
    logic [31:0] exp_dat  [NCYC];
    bit          exp_err  [NCYC];
    bit          exp_ack  [NCYC];
    bit          exp_bank [NCYC];

    logic [31:0] mref [int];
    logic [31:0] model_last = '0;
    int          front      = 0;
    int          ack_cycle  = -10;
    int          last_rd    = -10;
    bit          pend       = 1'b0;

    function automatic int key(input int bank, input logic [AW-1:0] a);
        return bank * (1 << 20) + int'(a);
    endfunction

    function automatic logic [31:0] peek(input int k);
        if (mref.exists(k)) return mref[k];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    // Apply the buffer's rules to the inputs of the current cycle.
    task automatic model_cycle();
        int          k;
        int          tgt;
        bit          oor_w;
        bit          oor_r;
        logic [31:0] old;
        logic [31:0] mask;
        k     = cyc;
        oor_w = int'(wr_addr) >= DEPTH;
        oor_r = int'(rd_addr) >= DEPTH;
        exp_err[k+1] = (wr_en && oor_w) || (rd_en && oor_r);
        if (rd_en) begin
            exp_rv[k+2]  = 1'b1;
            exp_dat[k+2] = oor_r ? 32'h0 : peek(key(front, rd_addr));
            last_rd      = k;
        end
`ifdef VGA_FB_DOUBLE_BUF_EN
        tgt = (k == ack_cycle) ? front : 1 - front;
`else
        tgt = 0;
`endif
        if (wr_en && !oor_w) begin
            old = peek(key(tgt, wr_addr));
            for (int i = 0; i < 4; i++) begin
                mask[i*8 +: 8] = {8{wr_be[i]}};
            end
            mref[key(tgt, wr_addr)] = (old & ~mask) | (wr_data & mask);
        end
`ifdef VGA_FB_DOUBLE_BUF_EN
        if (pend && !rd_en && last_rd < k - 2) begin
            pend         = 1'b0;
            ack_cycle    = k + 1;
            exp_ack[k+1] = 1'b1;
            front        = 1 - front;
        end else if (!pend && k != ack_cycle && swap_req) begin
            pend = 1'b1;
        end
`else
        exp_ack[k+1] = swap_req;
`endif
        exp_bank[k+1] = front[0];
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (exp_rv[cyc]) model_last = exp_dat[cyc];
        chk("rd_valid", 32'(rd_valid), 32'(exp_rv[cyc]));
        chk("rd_data", rd_data, model_last);
        chk("addr_err", 32'(addr_err), 32'(exp_err[cyc]));
        chk("swap_ack", 32'(swap_ack), 32'(exp_ack[cyc]));
        chk("active_bank", 32'(active_bank), 32'(exp_bank[cyc]));
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        wr_be   = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic rd_issue(input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rv"}, 32'(rd_valid), 32'h0);
        chk({tag, "_rd"}, rd_data, 32'h0);
        chk({tag, "_ack"}, 32'(swap_ack), 32'h0);
        chk({tag, "_err"}, 32'(addr_err), 32'h0);
        chk({tag, "_bank"}, 32'(active_bank), 32'h0);
    endtask

    function automatic int pick_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return r;
        if (r < 18) return DEPTH - 1;
        return DEPTH + int'($urandom_range(0, 15));
    endfunction

    initial begin
        resetn  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_addr = '0;
        idle();
        @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        cyc    = 0;

        // Fill a working set in both banks with full-word writes.
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 16; a++) wr(a, $urandom, 4'hF);
            wr(DEPTH - 1, $urandom, 4'hF);
            do_swap();
        end

        wr(5, 32'hDEADBEEF, 4'hF);
        do_swap();
        rd_issue(5);
        chk("req034_early", 32'(rd_valid), 32'h0);
        tick();
        chk("req034_valid", 32'(rd_valid), 32'h1);
        chk("req034_data", rd_data, 32'hDEADBEEF);

        wr(9, 32'h11223344, 4'hF);
        wr(9, 32'hAABBCCDD, 4'b0101);
        do_swap();
        rd_issue(9);
        tick();
        chk("req035_data", rd_data, 32'h11BB33DD);

        wr(DEPTH, 32'hCAFEF00D, 4'hF);
        chk("req037_werr", 32'(addr_err), 32'h1);
        rd_issue(DEPTH);
        chk("req037_rerr", 32'(addr_err), 32'h1);
        tick();
        chk("req037_rv", 32'(rd_valid), 32'h1);
        chk("req037_rd", rd_data, 32'h0);

        wr(3, 32'h5, 4'hF);
        do_swap();
        wr_en   = 1'b1;
        wr_addr = AW'(3);
        wr_data = 32'h7;
        wr_be   = 4'hF;
        rd_en   = 1'b1;
        rd_addr = AW'(3);
        tick();
        idle();
        tick();
        chk("req039_data", rd_data, 32'h5);
        repeat (2) tick();

        // Reset with a read in flight.
        rd_issue(5);
        resetn = 1'b0;
        #1;
        chk_zero("rst_async");
        for (int i = cyc; i < cyc + 4; i++) begin
            exp_rv[i]  = 1'b0;
            exp_err[i] = 1'b0;
            exp_ack[i] = 1'b0;
        end
        front      = 0;
        pend       = 1'b0;
        ack_cycle  = -10;
        last_rd    = -10;
        model_last = '0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        resetn = 1'b1;
        chk_zero("rst_rel");
        repeat (3) tick();

        // Swap requested under three back-to-back reads.
        swap_req = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = AW'(5);
        tick();
`ifndef VGA_FB_DOUBLE_BUF_EN
        chk("req036_ack1", 32'(swap_ack), 32'h1);
`endif
        swap_req = 1'b0;
        tick();
        tick();
        rd_en = 1'b0;
        tick();
        chk("req036_lastrv", 32'(rd_valid), 32'h1);
        tick();
`ifdef VGA_FB_DOUBLE_BUF_EN
        chk("req036_noack", 32'(swap_ack), 32'h0);
        chk("req036_bank0", 32'(active_bank), 32'h0);
`endif
        tick();
`ifdef VGA_FB_DOUBLE_BUF_EN
        chk("req036_ack", 32'(swap_ack), 32'h1);
        chk("req036_bank1", 32'(active_bank), 32'h1);
`else
        chk("req036_bank", 32'(active_bank), 32'h0);
`endif

        // Random mixed traffic.
        for (int n = 0; n < 300; n++) begin
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'(pick_addr());
            wr_data  = $urandom;
            wr_be    = 4'($urandom);
            rd_en    = ($urandom_range(0, 1) == 0);
            rd_addr  = AW'(pick_addr());
            swap_req = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_buf.md
VGA_FRAME_BUF -- requirements
Module: vga_frame_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits, multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 17: word address width.
REQ-003 Parameter DEPTH, default 76800: words per bank (640*480 bytes / 4).
REQ-004 Port clk, input, 1: single clock; all logic rising-edge.
REQ-005 Port resetn, input, 1: reset is asynchronous and active-low.
REQ-006 Port wr_en, input, 1: write strobe.
REQ-007 Port wr_addr, input, ADDR_WIDTH: write word address.
REQ-008 Port wr_data, input, DATA_WIDTH: write data.
REQ-009 Port wr_be, input, DATA_WIDTH/8: byte enables; bit i enables byte i.
REQ-010 Port rd_en, input, 1: read request.
REQ-011 Port rd_addr, input, ADDR_WIDTH: read word address.
REQ-012 Port rd_data, output, DATA_WIDTH: read data, valid when rd_valid high.
REQ-013 Port rd_valid, output, 1: one-cycle pulse per accepted read.
REQ-014 Port swap_req, input, 1: request front/back bank exchange.
REQ-015 Port swap_ack, output, 1: one-cycle pulse when the swap takes effect.
REQ-016 Port active_bank, output, 1: index of current front (read) bank.
REQ-017 Port addr_err, output, 1: one-cycle pulse on any out-of-range access.

Function
REQ-018 Writes SHALL go to the back bank; reads SHALL come from the front bank.
REQ-019 Write SHALL commit in the cycle wr_en is sampled; only bytes with wr_be set change.
REQ-020 Read latency SHALL be 2 cycles: rd_en at cycle N -> rd_valid and rd_data at N+2; back-to-back reads every cycle.
REQ-021 rd_data SHALL hold its last value while rd_valid is low.
REQ-022 Address >= DEPTH: write dropped; read returns zero with rd_valid; addr_err pulses at N+1.
REQ-023 Swap FSM states IDLE, PEND, SWAP; IDLE->PEND on swap_req; PEND->SWAP when no read in flight and rd_en low; SWAP->IDLE unconditionally.
REQ-024 In SWAP, active_bank SHALL toggle and swap_ack SHALL pulse for that cycle.
REQ-025 swap_req while in PEND or SWAP SHALL be ignored (no queueing).
REQ-026 Write in same cycle as SWAP SHALL land in the pre-swap back bank.
REQ-027 rd_en while in PEND SHALL be accepted and extends PEND until its data returns.

Reset
REQ-028 On resetn low: rd_valid=0, rd_data=0, swap_ack=0, addr_err=0, active_bank=0, FSM=IDLE, read pipeline flushed.
REQ-029 Memory contents SHALL NOT be reset; reads in flight at reset SHALL be discarded.

Configuration
REQ-030 Macro VGA_FB_DOUBLE_BUF_EN defined: two banks, swap FSM per REQ-023..027.
REQ-031 Macro undefined: one bank serves reads and writes; active_bank tied 0; swap_ack pulses the cycle after swap_req; same-address read/write in one cycle returns old data (read-first).

Structure
REQ-032 Package vga_fb_pkg SHALL hold the swap state enum, default parameter constants and the bank-index typedef.
REQ-033 Sub-module vga_fb_bank SHALL implement one byte-enable RAM bank with registered read; instantiated once or twice per macro.

Verification
REQ-034 Write 0xDEADBEEF to addr 5 with wr_be=4'hF, swap, rd_en addr 5 -> rd_data=0xDEADBEEF exactly 2 cycles later.
REQ-035 Write 0x11223344 then 0xAABBCCDD with wr_be=4'b0101 to addr 9, swap, read -> 0x11BB33DD.
REQ-036 swap_req with rd_en high 3 consecutive cycles -> swap_ack 2 cycles after last rd_valid; active_bank 0->1.
REQ-037 Write addr 76800 -> addr_err pulse, no memory change; read addr 76800 -> rd_data=0, rd_valid=1.
REQ-038 resetn low one cycle after rd_en -> no rd_valid; all outputs 0 on release.
REQ-039 Without VGA_FB_DOUBLE_BUF_EN: write 0x5 then same-cycle read/write addr 3 with 0x7 -> read returns 0x5.
